// File: rtl/piso_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_tx
// Description : Parallel-in/serial-out transmitter, MSB first, with a
//               valid/ready load. Optional even parity with macro PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame_active,
    output logic             parity_active,
    output logic             done,
    output logic             busy
);

    localparam int                C_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0]   C_CNT_INIT = C_CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [C_CW-1:0]  r_cnt;
    logic             r_serial;
    logic             r_frame;
    logic             w_last;
    logic             w_accept;
`ifdef PARITY_EN
    logic             r_parity;
    logic             r_par_act;
`endif

    assign w_accept = load_valid && load_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (r_cnt == '0) begin
`ifdef PARITY_EN
                    w_next_state = S_PARITY;
`else
                    w_next_state = w_accept ? S_DATA : S_IDLE;
`endif
                end
            end
            S_PARITY: begin
                w_next_state = w_accept ? S_DATA : S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: the last-bit cycle is the only frame cycle that accepts
    always_comb begin
        w_last = 1'b0;
`ifdef PARITY_EN
        w_last = (r_state == S_PARITY);
`else
        w_last = (r_state == S_DATA) && (r_cnt == '0);
`endif
        load_ready = (r_state == S_IDLE) || w_last;
        done       = w_last;
        busy       = (r_state != S_IDLE);
    end

    // Datapath: r_shift holds the bits still to be sent, left-aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_serial  <= 1'b0;
            r_frame   <= 1'b0;
`ifdef PARITY_EN
            r_parity  <= 1'b0;
            r_par_act <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift   <= {data_in[WIDTH-2:0], 1'b0};
            r_cnt     <= C_CNT_INIT;
            r_serial  <= data_in[WIDTH-1];
            r_frame   <= 1'b1;
`ifdef PARITY_EN
            r_parity  <= ^data_in;
            r_par_act <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_DATA: begin
                    if (r_cnt != '0) begin
                        r_serial <= r_shift[WIDTH-1];
                        r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
                        r_cnt    <= r_cnt - 1'b1;
                    end else begin
                        r_frame  <= 1'b0;
`ifdef PARITY_EN
                        r_serial  <= r_parity;
                        r_par_act <= 1'b1;
`else
                        r_serial <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_serial  <= 1'b0;
                    r_frame   <= 1'b0;
`ifdef PARITY_EN
                    r_par_act <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign serial_out   = r_serial;
    assign frame_active = r_frame;
`ifdef PARITY_EN
    assign parity_active = r_par_act;
`else
    assign parity_active = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer_tx
// Description : Scoreboard bench for piso_serializer_tx (WIDTH=4), with a
//               downstream 4-bit SIPO model. Honours PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer_tx;

    localparam int WIDTH = 4;
`ifdef PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    typedef struct packed {
        logic s;
        logic fa;
        logic pa;
        logic dn;
    } item_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             load_valid = 1'b0;
    logic             load_ready, serial_out, frame_active, parity_active, done, busy;
    logic [WIDTH-1:0] sipo = '0;

    item_t sb[$];
    item_t e;
    int    n_checks = 0;
    int    n_fail   = 0;

    piso_serializer_tx #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .frame_active (frame_active),
        .parity_active(parity_active),
        .done         (done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit serial-in/parallel-out register
    always @(posedge clk) if (frame_active) sipo <= {sipo[WIDTH-2:0], serial_out};

    task automatic push_frame(input logic [WIDTH-1:0] d);
        for (int k = 0; k < WIDTH; k++)
            sb.push_back('{s: d[WIDTH-1-k], fa: 1'b1, pa: 1'b0, dn: (k == WIDTH-1) && (FL == WIDTH)});
        if (FL != WIDTH) sb.push_back('{s: ^d, fa: 1'b0, pa: 1'b1, dn: 1'b1});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({serial_out, frame_active, parity_active, done, load_ready, busy} !== 6'b000010) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got s/fa/pa/dn/rdy/busy=%b required 000010", i,
                         {serial_out, frame_active, parity_active, done, load_ready, busy});
            end
        end
    endtask

    task automatic test_single();
        data_in = 4'b1011; load_valid = 1'b1;
        push_frame(4'b1011);
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({serial_out, frame_active, parity_active, done, load_ready, busy} !== {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1}) begin
                n_fail++;
                $display("FAIL single cyc%0d: got s/fa/pa/dn/rdy/busy=%b required %b", c,
                         {serial_out, frame_active, parity_active, done, load_ready, busy},
                         {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1});
            end
        end
        @(negedge clk);
        n_checks++;
        if (sipo !== 4'b1011) begin
            n_fail++;
            $display("FAIL single_sipo: got %b required 1011", sipo);
        end
        n_checks++;
        if ({serial_out, frame_active, busy, load_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_end_idle: got s/fa/busy/rdy=%b required 0001",
                     {serial_out, frame_active, busy, load_ready});
        end
    endtask

    task automatic test_back_to_back();
        int n_done = 0;
        data_in = 4'hA; load_valid = 1'b1;
        push_frame(4'hA);
        push_frame(4'h5);
        for (int c = 0; c < 2*FL; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            if (done) n_done++;
            n_checks++;
            if ({serial_out, frame_active, parity_active, done, load_ready, busy} !== {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1}) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got s/fa/pa/dn/rdy/busy=%b required %b", c,
                         {serial_out, frame_active, parity_active, done, load_ready, busy},
                         {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1});
            end
            if (c == 0) data_in = 4'h5;
            if (c == FL) load_valid = 1'b0;
        end
        n_checks++;
        if (n_done != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d required 2", n_done);
        end
        @(negedge clk);
        n_checks++;
        if (sipo !== 4'h5) begin
            n_fail++;
            $display("FAIL b2b_sipo: got %h required 5", sipo);
        end
    endtask

    task automatic test_ignore_valid();
        data_in = 4'h6; load_valid = 1'b1;
        push_frame(4'h6);
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if ({serial_out, frame_active, parity_active, done, load_ready, busy} !== {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1}) begin
                n_fail++;
                $display("FAIL ignore cyc%0d: got s/fa/pa/dn/rdy/busy=%b required %b", c,
                         {serial_out, frame_active, parity_active, done, load_ready, busy},
                         {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1});
            end
            if (c == 0) load_valid = 1'b0;
            if (c == 1) begin data_in = 4'hF; load_valid = 1'b1; end
            if (c == 2) begin data_in = 4'h6; load_valid = 1'b0; end
        end
        @(negedge clk);
        n_checks++;
        if ({busy, frame_active, sipo} !== {2'b00, 4'h6}) begin
            n_fail++;
            $display("FAIL ignore_end: got busy/fa/sipo=%b required 000110", {busy, frame_active, sipo});
        end
    endtask

    task automatic test_reset_mid_frame();
        data_in = 4'hC; load_valid = 1'b1;
        push_frame(4'hC);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({serial_out, frame_active, busy} !== {e.s, e.fa, 1'b1}) begin
                n_fail++;
                $display("FAIL abort_pre cyc%0d: got s/fa/busy=%b required %b", c,
                         {serial_out, frame_active, busy}, {e.s, e.fa, 1'b1});
            end
        end
        sb.delete();
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({serial_out, frame_active, parity_active, done, busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL abort_async: got s/fa/pa/dn/busy=%b required 00000",
                     {serial_out, frame_active, parity_active, done, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({load_ready, busy, serial_out} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_release: got rdy/busy/s=%b required 100", {load_ready, busy, serial_out});
        end
        data_in = 4'h3; load_valid = 1'b1;
        push_frame(4'h3);
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({serial_out, frame_active, parity_active, done, load_ready, busy} !== {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1}) begin
                n_fail++;
                $display("FAIL after_abort cyc%0d: got s/fa/pa/dn/rdy/busy=%b required %b", c,
                         {serial_out, frame_active, parity_active, done, load_ready, busy},
                         {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1});
            end
        end
    endtask

    task automatic test_parity_word();
        data_in = 4'b0111; load_valid = 1'b1;
        push_frame(4'b0111);
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            load_valid = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({serial_out, frame_active, parity_active, done, load_ready, busy} !== {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1}) begin
                n_fail++;
                $display("FAIL parity_word cyc%0d: got s/fa/pa/dn/rdy/busy=%b required %b", c,
                         {serial_out, frame_active, parity_active, done, load_ready, busy},
                         {e.s, e.fa, e.pa, e.dn, e.dn, 1'b1});
            end
        end
        @(negedge clk);
        n_checks++;
        if ({busy, parity_active, serial_out, sipo} !== {3'b000, 4'b0111}) begin
            n_fail++;
            $display("FAIL parity_word_end: got busy/pa/s/sipo=%b required 0000111",
                     {busy, parity_active, serial_out, sipo});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_valid();
        test_reset_mid_frame();
        test_parity_word();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
